// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined sign/biased-exponent/hidden-1 floating-point multiplier
// with valid/ready flow control, truncate/RNE rounding, saturation and flush-to-zero.
module fp_mult_pipe #(
    parameter int NB_EXP   = 4,
    parameter int NB_MANT  = 5,
    parameter int NB_TOTAL = NB_EXP + NB_MANT + 1
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [NB_TOTAL-1:0] i_a,
    input  logic [NB_TOTAL-1:0] i_b,
    input  logic                i_rnd,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [NB_TOTAL-1:0] o_c,
    output logic                o_ovf,
    output logic                o_unf
);

    localparam int NB_PROD = 2 * NB_MANT + 2;
    localparam int NB_ESUM = NB_EXP + 2;
    localparam logic [NB_ESUM-1:0] BIAS     = NB_ESUM'((1 << (NB_EXP - 1)) - 1);
    localparam logic [NB_ESUM-1:0] EXP_MAX  = NB_ESUM'((1 << NB_EXP) - 1);
    localparam logic [NB_ESUM-1:0] ESUM_ONE = NB_ESUM'(1);

    logic               s1_valid, s1_sign, s1_zero, s1_rnd;
    logic [NB_PROD-1:0] s1_prod;
    logic [NB_ESUM-1:0] s1_esum;

    logic               s2_valid, s2_sign, s2_zero;
    logic [NB_ESUM-1:0] s2_esum;
    logic [NB_MANT-1:0] s2_frac;

    logic s1_load, s2_load, s3_load;

    // Ready chain: a stage may load when empty or when its successor drains it.
    assign s3_load = !o_valid || i_ready;
    assign s2_load = !s2_valid || s3_load;
    assign s1_load = !s1_valid || s2_load;
    assign o_ready = s1_load;

    logic [NB_EXP-1:0]  exp_a, exp_b;
    logic [NB_PROD-1:0] prod_c;
    logic [NB_ESUM-1:0] esum_c;
    logic               zero_c;

    assign exp_a  = i_a[NB_TOTAL-2 -: NB_EXP];
    assign exp_b  = i_b[NB_TOTAL-2 -: NB_EXP];
    assign zero_c = (exp_a == '0) || (exp_b == '0);
    assign prod_c = NB_PROD'({1'b1, i_a[NB_MANT-1:0]}) * NB_PROD'({1'b1, i_b[NB_MANT-1:0]});
    assign esum_c = NB_ESUM'(exp_a) + NB_ESUM'(exp_b) - BIAS;

    logic [NB_PROD-2:0] norm;
    logic [NB_MANT-1:0] frac_t;
    logic               guard_bit, sticky_bit, round_up;
    logic [NB_MANT:0]   frac_sum;
    logic [NB_ESUM-1:0] esum_norm, esum_r;

    // Drop the hidden bit after aligning it to the top; P < 4*2^(2*NB_MANT) so one shift suffices.
    assign norm       = s1_prod[NB_PROD-1] ? s1_prod[NB_PROD-2:0]
                                           : {s1_prod[NB_PROD-3:0], 1'b0};
    assign esum_norm  = s1_esum + NB_ESUM'(s1_prod[NB_PROD-1]);
    assign frac_t     = norm[NB_PROD-2 -: NB_MANT];
    assign guard_bit  = norm[NB_PROD-NB_MANT-2];
    assign sticky_bit = |norm[NB_PROD-NB_MANT-3:0];
    assign round_up   = s1_rnd && guard_bit && (sticky_bit || frac_t[0]);
    assign frac_sum   = {1'b0, frac_t} + (NB_MANT + 1)'(round_up);
    assign esum_r     = esum_norm + NB_ESUM'(frac_sum[NB_MANT]);

    logic [NB_TOTAL-1:0] c_c;
    logic                ovf_c, unf_c;

    always_comb begin
        ovf_c = 1'b0;
        unf_c = 1'b0;
        c_c   = {s2_sign, {(NB_TOTAL-1){1'b0}}};
        if (!s2_zero) begin
            if ($signed(s2_esum) > $signed(EXP_MAX)) begin
                c_c   = {s2_sign, {(NB_TOTAL-1){1'b1}}};
                ovf_c = 1'b1;
            end else if ($signed(s2_esum) < $signed(ESUM_ONE)) begin
                unf_c = 1'b1;
            end else begin
                c_c = {s2_sign, s2_esum[NB_EXP-1:0], s2_frac};
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_rnd   <= 1'b0;
            s1_prod  <= '0;
            s1_esum  <= '0;
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_zero  <= 1'b0;
            s2_esum  <= '0;
            s2_frac  <= '0;
            o_valid  <= 1'b0;
            o_c      <= '0;
            o_ovf    <= 1'b0;
            o_unf    <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= i_valid;
                s1_sign  <= i_a[NB_TOTAL-1] ^ i_b[NB_TOTAL-1];
                s1_zero  <= zero_c;
                s1_rnd   <= i_rnd;
                s1_prod  <= prod_c;
                s1_esum  <= esum_c;
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                s2_sign  <= s1_sign;
                s2_zero  <= s1_zero;
                // A round carry-out leaves frac_sum's low bits at zero already.
                s2_frac  <= frac_sum[NB_MANT-1:0];
                s2_esum  <= esum_r;
            end
            if (s3_load) begin
                o_valid <= s2_valid;
                o_c     <= s2_valid ? c_c   : '0;
                o_ovf   <= s2_valid ? ovf_c : 1'b0;
                o_unf   <= s2_valid ? unf_c : 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe: directed cases plus randomized traffic scored
// against an integer-arithmetic reference model and a FIFO scoreboard.
module tb_fp_mult_pipe;

    logic       i_clock = 1'b0;
    logic       i_reset, i_valid, i_ready, i_rnd;
    logic [9:0] i_a, i_b;
    logic       o_ready, o_valid, o_ovf, o_unf;
    logic [9:0] o_c;

    fp_mult_pipe dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_rnd   (i_rnd),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_c     (o_c),
        .o_ovf   (o_ovf),
        .o_unf   (o_unf)
    );

    always #5 i_clock = ~i_clock;

    int cyc = 0;
    always @(posedge i_clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];
    int          lat_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
            $error("%s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Returns {ovf, unf, c}: exact product rescaled to a 6-bit significand by division.
    function automatic logic [11:0] model(input logic [9:0] a, input logic [9:0] b, input logic rnd);
        logic s;
        int ea, eb, p, e, sh, q, rem, half;
        s  = a[9] ^ b[9];
        ea = int'(a[8:5]);
        eb = int'(b[8:5]);
        if (ea == 0 || eb == 0) return {2'b00, s, 9'b0};
        p  = (32 + int'(a[4:0])) * (32 + int'(b[4:0]));
        e  = ea + eb - 7;
        sh = 0;
        while ((p >> sh) >= 64) sh++;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 1 << (sh - 1);
        e    = e + sh - 5;
        if (rnd && (rem > half || (rem == half && (q % 2) == 1))) q++;
        if (q == 64) begin
            q = 32;
            e++;
        end
        if (e > 15) return {2'b10, s, 9'h1FF};
        if (e < 1) return {2'b01, s, 9'b0};
        return {2'b00, s, e[3:0], q[4:0]};
    endfunction

    // One cycle: score any output transfer, record any input transfer, advance to next negedge.
    task automatic step(input string tag, input logic [11:0] e, input bit lat);
        logic [11:0] eo;
        int l;
        #1;
        if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_spurious_valid"}, 32'(o_valid), 32'd0);
            end else begin
                eo = exp_q.pop_front();
                l  = lat_q.pop_front();
                chk({tag, "_c"}, 32'(o_c), 32'(eo[9:0]));
                chk({tag, "_ovf"}, 32'(o_ovf), 32'(eo[11]));
                chk({tag, "_unf"}, 32'(o_unf), 32'(eo[10]));
                if (l >= 0) chk({tag, "_latency"}, 32'(cyc - l), 32'd3);
            end
        end
        if (i_valid && o_ready) begin
            exp_q.push_back(e);
            lat_q.push_back(lat ? cyc : -1);
        end
        @(negedge i_clock);
    endtask

    task automatic drain(input string tag);
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) step(tag, 12'h0, 1'b0);
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    logic [9:0]  da[7], db[7];
    logic        dr[7];
    logic [11:0] de[7];
    logic [9:0]  bpa[5], bpb[5];
    logic [9:0]  held;
    int          idx;

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_a     = '0;
        i_b     = '0;
        i_rnd   = 1'b0;
        repeat (3) @(negedge i_clock);
        i_reset = 1'b0;
        #1;
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_c", 32'(o_c), 32'd0);
        chk("reset_ovf", 32'(o_ovf), 32'd0);
        chk("reset_unf", 32'(o_unf), 32'd0);
        chk("reset_ready", 32'(o_ready), 32'd1);
        @(negedge i_clock);

        // Basic 5 x 10 = 50
        i_valid = 1'b1;
        i_a = 10'b0_1001_01000;
        i_b = 10'b0_1010_01000;
        i_rnd = 1'b0;
        step("basic", {2'b00, 10'b0_1100_10010}, 1'b1);
        drain("basic");

        // Back-to-back directed stream
        da[0] = 10'b0_0110_00000; db[0] = 10'b0_1010_01000; dr[0] = 1'b0; de[0] = {2'b00, 10'b0_1001_01000};
        da[1] = 10'b0_1000_01100; db[1] = 10'b1_1000_10110; dr[1] = 1'b0; de[1] = {2'b00, 10'b1_1010_00101};
        da[2] = 10'b0_0111_10001; db[2] = 10'b0_0111_10001; dr[2] = 1'b0; de[2] = {2'b00, 10'b0_1000_00101};
        da[3] = 10'b0_0111_10001; db[3] = 10'b0_0111_10001; dr[3] = 1'b1; de[3] = {2'b00, 10'b0_1000_00110};
        da[4] = 10'b0_1111_00000; db[4] = 10'b0_1111_00000; dr[4] = 1'b0; de[4] = {2'b10, 10'b0_1111_11111};
        da[5] = 10'b0_0001_00000; db[5] = 10'b0_0001_00000; dr[5] = 1'b0; de[5] = {2'b01, 10'b0_0000_00000};
        da[6] = 10'b0_0000_00000; db[6] = 10'b1_1001_01000; dr[6] = 1'b0; de[6] = {2'b00, 10'b1_0000_00000};
        i_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            i_valid = 1'b1;
            i_a = da[k];
            i_b = db[k];
            i_rnd = dr[k];
            #1;
            chk("stream_ready", 32'(o_ready), 32'd1);
            step("stream", de[k], 1'b1);
        end
        drain("stream");

        // Backpressure: 5 offered with the sink stalled
        for (int k = 0; k < 5; k++) begin
            bpa[k] = 10'($urandom_range(32, 1023));
            bpb[k] = 10'($urandom_range(32, 1023));
        end
        i_ready = 1'b0;
        i_rnd   = 1'b1;
        idx     = 0;
        for (int k = 0; k < 5; k++) begin
            i_valid = 1'b1;
            i_a = bpa[idx];
            i_b = bpb[idx];
            if (o_ready) begin
                step("bp", model(bpa[idx], bpb[idx], 1'b1), 1'b0);
                idx++;
            end else begin
                step("bp", 12'h0, 1'b0);
            end
        end
        #1;
        chk("bp_accepted", 32'(idx), 32'd3);
        chk("bp_ready_low", 32'(o_ready), 32'd0);
        chk("bp_valid_held", 32'(o_valid), 32'd1);
        held = o_c;
        repeat (2) step("bp", 12'h0, 1'b0);
        #1;
        chk("bp_c_stable", 32'(o_c), 32'(held));
        i_ready = 1'b1;
        for (int k = 0; k < 20 && idx < 5; k++) begin
            i_valid = 1'b1;
            i_a = bpa[idx];
            i_b = bpb[idx];
            #1;
            if (o_ready) begin
                step("bp", model(bpa[idx], bpb[idx], 1'b1), 1'b0);
                idx++;
            end else begin
                step("bp", 12'h0, 1'b0);
            end
        end
        chk("bp_all_accepted", 32'(idx), 32'd5);
        drain("bp");

        // Reset with three results in flight
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1;
            i_a = 10'b0_1001_01000;
            i_b = 10'b0_1010_01000;
            step("rst_fill", {2'b00, 10'b0_1100_10010}, 1'b0);
        end
        i_valid = 1'b0;
        i_reset = 1'b1;
        @(negedge i_clock);
        i_reset = 1'b0;
        exp_q.delete();
        lat_q.delete();
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_c", 32'(o_c), 32'd0);
        chk("rst_flags", 32'({o_ovf, o_unf}), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        @(negedge i_clock);
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_a = 10'b0_1001_01000;
        i_b = 10'b0_1010_01000;
        i_rnd = 1'b0;
        step("post_rst", {2'b00, 10'b0_1100_10010}, 1'b1);
        drain("post_rst");

        // Randomized traffic with random stalls on both sides
        for (int k = 0; k < 400; k++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            i_a     = 10'($urandom);
            i_b     = 10'($urandom);
            i_rnd   = 1'($urandom);
            step("rand", model(i_a, i_b, i_rnd), 1'b0);
        end
        drain("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
- Pipelined, parametrised sign/biased-exponent/hidden-1 floating-point multiplier; successor to the combinational floating-point multiplier.
- Three register stages with valid/ready flow control, selectable rounding, saturation and flush-to-zero, and status flags.
- Sits between an operand source and a result sink that can both stall.

Parameters:
- NB_EXP, 4, exponent width; bias = 2^(NB_EXP-1)-1 (7 at default).
- NB_MANT, 5, stored fraction width (hidden 1 not stored).
- NB_TOTAL, NB_EXP+NB_MANT+1, word width {sign, exp, frac}.

Ports:
- i_clock  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  operand pair valid.
- o_ready  out 1  block can accept an operand pair this cycle.
- i_a  in  NB_TOTAL  operand A.
- i_b  in  NB_TOTAL  operand B.
- i_rnd  in  1  rounding mode, sampled with operands: 0 = truncate, 1 = round-to-nearest-even.
- o_valid  out 1  result valid.
- i_ready  in  1  sink accepts result.
- o_c  out NB_TOTAL  product.
- o_ovf  out 1  overflow, product saturated.
- o_unf  out 1  underflow, product flushed to zero.

Behaviour:
- Clock and reset: one clock (i_clock); reset (i_reset) is synchronous and active-high.
- Reset:
  - All stage valid bits clear at the next edge.
  - o_valid=0, o_c=0, o_ovf=0, o_unf=0.
  - o_ready=1 from the first cycle after reset.
  - Reset mid-flight discards all in-flight operations; no partial result emerges.
- Handshake:
  - Input transfer when i_valid&&o_ready.
  - Output transfer when o_valid&&i_ready.
  - o_c/o_ovf/o_unf are held stable while o_valid&&!i_ready.
- Pipeline: S1 → S2 → S3 (S3 = output register).
  - Stage k loads when it is empty or stage k+1 advances that cycle.
  - S3 advances on i_ready.
  - o_ready = !S1_valid || S1 advances (combinational ready chain; no bubble when i_ready=1).
  - Capacity 3 results.
  - Latency: result appears on o_valid exactly 3 cycles after the accepting edge when unstalled.
  - Throughput: 1 result per cycle.
  - Ordering is strictly FIFO.
- S1:
  - sign = sa^sb.
  - Zero detection: an operand with exp==0 is zero (denormals flushed).
  - ma = {1,frac_a}, mb = {1,frac_b} (NB_MANT+1 bits each); product P is 2*NB_MANT+2 bits.
  - esum = ea+eb-bias, signed, NB_EXP+2 bits.
- S2:
  - If P MSB=1: shift right by 1 and esum+1.
  - Fraction = next NB_MANT bits; guard = next bit; sticky = OR of the remaining bits.
  - RNE: increment when guard && (sticky || frac LSB).
  - A round carry-out sets frac=0 and esum+1.
- S3, in priority order:
  - Zero operand → o_c={sign,0...0}, no flags.
  - esum > 2^NB_EXP-1 → o_c={sign, all-ones exp, all-ones frac}, o_ovf=1.
  - esum < 1 → o_c={sign,0...0}, o_unf=1.
  - Otherwise pack {sign, esum[NB_EXP-1:0], frac}.
- Encoding: all exponent codes 1..2^NB_EXP-1 are finite; no Inf/NaN encoding.
- Flags are per result and qualified by o_valid.

Test Plan:
- Basic latency: i_a=0_1001_01000 (5), i_b=0_1010_01000 (10), i_rnd=0, i_ready=1 → o_valid exactly 3 cycles later, o_c=0_1100_10010 (50), flags 0.
- Streaming: back-to-back, one pair per cycle:
  - 0.5×10 → 0_1001_01000.
  - 2.75×-3.375, i.e. 0_1000_01100 × 1_1000_10110 → 1_1010_00101.
  - Results arrive on consecutive cycles in order; o_ready stays 1 throughout.
- Rounding: i_a=i_b=0_0111_10001 (1.53125):
  - i_rnd=0 → 0_1000_00101.
  - i_rnd=1 → 0_1000_00110.
  - Both issued back-to-back with differing i_rnd; each result reflects its own sampled i_rnd.
- Overflow/underflow/zero:
  - 0_1111_00000 × 0_1111_00000 → 0_1111_11111, o_ovf=1.
  - 0_0001_00000 × 0_0001_00000 → 0_0000_00000, o_unf=1.
  - 0×(-5), i.e. 0_0000_00000 × 1_1001_01000 → 1_0000_00000, no flags.
- Backpressure: i_ready=0 while offering 5 pairs:
  - Exactly 3 accepted; o_ready=0 afterwards.
  - o_c stable while stalled.
  - Raising i_ready drains all 5 in order with no loss or duplication.
- Reset mid-flight: assert i_reset with 3 results in flight →
  - Next cycle: o_valid=0, outputs 0, o_ready=1.
  - A subsequent 5×10 returns 50 with 3-cycle latency.
